// File: rtl/ps2_host_tx_if.sv
// Command-side handshake plus raw PS/2 pin levels and open-collector enables
// for the host-to-device PS/2 transmitter.
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       done;
  logic       error;
  logic       ps2_clk_in;
  logic       ps2_data_in;
  logic       ps2_clk_oe;
  logic       ps2_data_oe;

  modport master (
    output tx_data, tx_valid, ps2_clk_in, ps2_data_in,
    input  tx_ready, busy, done, error, ps2_clk_oe, ps2_data_oe
  );

  modport slave (
    input  tx_data, tx_valid, ps2_clk_in, ps2_data_in,
    output tx_ready, busy, done, error, ps2_clk_oe, ps2_data_oe
  );
endinterface

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter (inhibit, request-to-send, 11-bit frame, ACK check).
// Optional macro PS2_TX_RETRY_EN: retry a failed frame up to 2 times before reporting error.
module ps2_host_tx #(
  parameter int CLK_HZ      = 100_000_000,
  parameter int INHIBIT_US  = 120,
  parameter int START_TO_US = 15000,
  parameter int FRAME_TO_US = 2000
) (
  input logic          clk,
  input logic          rst,
  ps2_host_tx_if.slave bus
);

  function automatic logic [31:0] us_to_cyc(input int us);
    return 32'((64'(us) * 64'(CLK_HZ)) / 64'd1_000_000);
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  localparam logic [31:0] INHIBIT_CYC = us_to_cyc(INHIBIT_US);
  localparam logic [31:0] START_CYC   = us_to_cyc(START_TO_US);
  localparam logic [31:0] FRAME_CYC   = us_to_cyc(FRAME_TO_US);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] INHIBIT  = 3'd1;
  localparam logic [2:0] RTS      = 3'd2;
  localparam logic [2:0] WAIT_CLK = 3'd3;
  localparam logic [2:0] SHIFT    = 3'd4;
  localparam logic [2:0] ACK      = 3'd5;
  localparam logic [2:0] DONE     = 3'd6;
  localparam logic [2:0] ERROR    = 3'd7;

  logic [2:0]  state;
  logic [31:0] timer;
  logic [3:0]  bit_cnt;
  logic [9:0]  frame;
  logic        clk_oe;
  logic        data_oe;
  logic        fail;
  logic        retry_ok;

  logic ps2c_p0, ps2c_p1, ps2c_p2;
  logic ps2d_p0, ps2d_p1;
  logic fall;

  // Stage p0/p1: two-flop synchronizers; p2 holds the previous clock sample for edge detect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ps2c_p0 <= 1'b1;
      ps2c_p1 <= 1'b1;
      ps2c_p2 <= 1'b1;
      ps2d_p0 <= 1'b1;
      ps2d_p1 <= 1'b1;
    end else begin
      ps2c_p0 <= bus.ps2_clk_in;
      ps2c_p1 <= ps2c_p0;
      ps2c_p2 <= ps2c_p1;
      ps2d_p0 <= bus.ps2_data_in;
      ps2d_p1 <= ps2d_p0;
    end
  end

  assign fall = ps2c_p2 & ~ps2c_p1;

  // Frame is {stop, odd parity, data}; only loaded on accept, so no reset needed.
  always_ff @(posedge clk) begin
    if (state == IDLE && bus.tx_valid)
      frame <= {1'b1, ~^bus.tx_data, bus.tx_data};
  end

  always_comb begin
    fail = 1'b0;
    case (state)
      WAIT_CLK: fail = !fall && (timer >= START_CYC - 32'd1);
      SHIFT:    fail = !fall && (timer >= FRAME_CYC - 32'd1);
      ACK:      fail = fall ? ps2d_p1 : (timer >= FRAME_CYC - 32'd1);
      default:  fail = 1'b0;
    endcase
  end

`ifdef PS2_TX_RETRY_EN
  logic [1:0] retry_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      retry_cnt <= 2'd0;
    else if (state == IDLE)
      retry_cnt <= 2'd0;
    else if (fail && retry_ok)
      retry_cnt <= retry_cnt + 2'd1;
  end

  assign retry_ok = (retry_cnt < 2'd2);
`else
  assign retry_ok = 1'b0;
`endif

  // One shared saturating timer: inhibit length, start timeout, then frame timeout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      timer   <= 32'd0;
      bit_cnt <= 4'd0;
      clk_oe  <= 1'b0;
      data_oe <= 1'b0;
    end else if (fail) begin
      timer   <= 32'd0;
      bit_cnt <= 4'd0;
      data_oe <= 1'b0;
      if (retry_ok) begin
        state  <= INHIBIT;
        clk_oe <= 1'b1;
      end else begin
        state  <= ERROR;
        clk_oe <= 1'b0;
      end
    end else begin
      timer <= sat_inc(timer);
      case (state)
        IDLE: begin
          timer   <= 32'd0;
          bit_cnt <= 4'd0;
          data_oe <= 1'b0;
          clk_oe  <= 1'b0;
          if (bus.tx_valid) begin
            state  <= INHIBIT;
            clk_oe <= 1'b1;
          end
        end
        INHIBIT: begin
          if (timer >= INHIBIT_CYC - 32'd1) begin
            data_oe <= 1'b1;
            state   <= RTS;
          end
        end
        RTS: begin
          clk_oe <= 1'b0;
          timer  <= 32'd0;
          state  <= WAIT_CLK;
        end
        WAIT_CLK: begin
          if (fall) begin
            data_oe <= ~frame[0];
            bit_cnt <= 4'd1;
            timer   <= 32'd0;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          if (fall) begin
            if (bit_cnt == 4'd10) begin
              data_oe <= 1'b0;
              state   <= ACK;
            end else begin
              data_oe <= ~frame[bit_cnt];
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
        end
        ACK: begin
          data_oe <= 1'b0;
          if (fall)
            state <= DONE;
        end
        default: begin
          clk_oe  <= 1'b0;
          data_oe <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

  assign bus.tx_ready    = (state == IDLE);
  assign bus.busy        = (state != IDLE);
  assign bus.done        = (state == DONE);
  assign bus.error       = (state == ERROR);
  assign bus.ps2_clk_oe  = clk_oe;
  assign bus.ps2_data_oe = data_oe;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-collector keyboard model with a scoreboard of expected frames.
`timescale 1ns/1ps
module tb_ps2_host_tx;
  localparam int CLK_HZ    = 1_000_000;
  localparam int INH_CYC   = 120;
  localparam int START_CYC = 15000;
  localparam int HALF      = 40;
`ifdef PS2_TX_RETRY_EN
  localparam int ATTEMPTS = 3;
`else
  localparam int ATTEMPTS = 1;
`endif

  typedef struct {
    logic [7:0] data;
    logic       par;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ps2_host_tx_if bus();

  ps2_host_tx #(
    .CLK_HZ(CLK_HZ), .INHIBIT_US(120), .START_TO_US(15000), .FRAME_TO_US(2000)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic dev_clk  = 1'b1;
  logic dev_data = 1'b1;
  assign bus.ps2_clk_in  = dev_clk  & ~bus.ps2_clk_oe;
  assign bus.ps2_data_in = dev_data & ~bus.ps2_data_oe;

  exp_t exp_q[$];
  exp_t last_exp;
  int   total = 0;
  int   bad = 0;
  int   dev_mode = 0;    // 0: ACK, 1: NACK, 2: never clocks
  int   inhibit_cnt = 0;
  int   release_seq = 0;
  int   fall_idx = 0;
  int   done_cnt = 0;
  int   err_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Watches every inhibit phase and counts result pulses.
  initial begin : inh_mon
    int  n;
    logic rts;
    n = 0;
    rts = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.done)  done_cnt++;
      if (bus.error) err_cnt++;
      if (rst) begin
        n = 0;
      end else if (bus.ps2_clk_oe) begin
        n++;
        rts = bus.ps2_data_oe;
      end else if (n > 0) begin
        inhibit_cnt++;
        chk("inhibit_len", 32'(n >= INH_CYC), 1);
        chk("rts_before_release", rts, 1);
        chk("start_held", bus.ps2_data_oe, 1);
        n = 0;
        release_seq++;
      end
    end
  end

  task automatic dev_wait(input int n, output bit ok);
    ok = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (rst) begin
        ok = 1'b0;
        return;
      end
    end
  endtask

  task automatic dev_frame();
    logic [10:0] bits;
    bit ok;
    bits = '0;
    fall_idx = 0;
    bits[0] = bus.ps2_data_in;
    for (int k = 1; k <= 12; k++) begin
      dev_wait(HALF, ok);
      if (!ok) begin dev_clk = 1'b1; dev_data = 1'b1; return; end
      dev_clk = 1'b0;
      fall_idx = k;
      dev_wait((k == 12) ? 8 : HALF, ok);
      if (!ok) begin dev_clk = 1'b1; dev_data = 1'b1; return; end
      dev_clk = 1'b1;
      if (k <= 10) bits[k] = bus.ps2_data_in;
      if (k == 11) dev_data = (dev_mode == 1);
      if (k == 12) dev_data = 1'b1;
    end
    if (exp_q.size() > 0) last_exp = exp_q.pop_front();
    chk("start_bit", 32'(bits[0]), 0);
    chk("data_byte", 32'(bits[8:1]), 32'(last_exp.data));
    chk("parity_bit", 32'(bits[9]), 32'(last_exp.par));
    chk("stop_bit", 32'(bits[10]), 1);
  endtask

  initial begin : device
    int seen;
    seen = 0;
    forever begin
      @(negedge clk);
      if (release_seq != seen) begin
        seen = release_seq;
        if (dev_mode != 2 && !rst) dev_frame();
      end
    end
  end

  task automatic accept(input logic [7:0] d, input logic p, input bit push, input bit hold);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!bus.tx_ready && guard < 1000) begin @(negedge clk); guard++; end
    chk("ready_wait", 32'(guard < 1000), 1);
    bus.tx_data  = d;
    bus.tx_valid = 1'b1;
    @(negedge clk);
    if (!hold) bus.tx_valid = 1'b0;
    if (push) exp_q.push_back('{data: d, par: p});
  endtask

  task automatic wait_result(input bit exp_done, input int limit);
    int n;
    n = 0;
    while (!(bus.done || bus.error) && n < limit) begin @(negedge clk); n++; end
    chk("result_seen", 32'(n < limit), 1);
    chk("done_pulse", bus.done, exp_done);
    chk("error_pulse", bus.error, !exp_done);
    @(negedge clk);
    chk("pulse_width", bus.done | bus.error, 0);
    chk("idle_ready", bus.tx_ready, 1);
    chk("idle_oe", {bus.ps2_clk_oe, bus.ps2_data_oe}, 0);
    repeat (10) @(negedge clk);
  endtask

  task automatic wait_fall(input int idx);
    int n;
    n = 0;
    while (fall_idx != idx && n < 5000) begin @(negedge clk); n++; end
    chk("reach_fall", 32'(n < 5000), 1);
  endtask

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    int d0, e0, n;
    bus.tx_data  = 8'h00;
    bus.tx_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_ready", bus.tx_ready, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_clk_oe", bus.ps2_clk_oe, 0);
    chk("rst_data_oe", bus.ps2_data_oe, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_error", bus.error, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // 0xED with ACK
    dev_mode = 0;
    d0 = done_cnt;
    accept(8'hED, 1'b1, 1'b1, 1'b0);
    wait_result(1'b1, 5000);
    chk("ed_done_once", 32'(done_cnt - d0), 1);
    chk("ed_q_empty", 32'(exp_q.size()), 0);

    // 0xF4: parity 0, busy during frame
    accept(8'hF4, 1'b0, 1'b1, 1'b0);
    chk("f4_busy", bus.busy, 1);
    chk("f4_not_ready", bus.tx_ready, 0);
    wait_result(1'b1, 5000);
    chk("f4_q_empty", 32'(exp_q.size()), 0);

    // Device never clocks: error START_CYC cycles after the last clock release
    dev_mode = 2;
    accept(8'h55, 1'b1, 1'b0, 1'b0);
    n = 0;
    for (int i = 0; i < ATTEMPTS * (START_CYC + INH_CYC + 100); i++) begin
      if (bus.error) break;
      if (bus.ps2_clk_oe) n = 0;
      else n++;
      @(negedge clk);
    end
    chk("start_timeout_cycles", 32'(n), 32'(START_CYC));
    wait_result(1'b0, 1);

    // NACK from device
    dev_mode = 1;
    inhibit_cnt = 0;
    d0 = done_cnt;
    accept(8'h12, 1'b1, 1'b1, 1'b0);
    wait_result(1'b0, 20000);
    chk("nack_attempts", 32'(inhibit_cnt), 32'(ATTEMPTS));
    chk("nack_no_done", 32'(done_cnt - d0), 0);
    chk("nack_q_empty", 32'(exp_q.size()), 0);

    // Async reset during inhibit, then during bit 4 of 0xFF
    dev_mode = 0;
    d0 = done_cnt;
    e0 = err_cnt;
    accept(8'h3C, 1'b0, 1'b0, 1'b0);
    repeat (20) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_inh_clk_oe", bus.ps2_clk_oe, 0);
    chk("rst_inh_busy", bus.busy, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    accept(8'hFF, 1'b1, 1'b0, 1'b0);
    wait_fall(5);
    repeat (20) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_bit4_oe", {bus.ps2_clk_oe, bus.ps2_data_oe}, 0);
    chk("rst_bit4_ready", bus.tx_ready, 1);
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_no_pulses", 32'((done_cnt - d0) + (err_cnt - e0)), 0);
    accept(8'hFF, 1'b1, 1'b1, 1'b0);
    wait_result(1'b1, 5000);
    chk("ff_q_empty", 32'(exp_q.size()), 0);

    // tx_valid held across the frame with tx_data changed mid-frame
    accept(8'hA5, 1'b1, 1'b1, 1'b1);
    wait_fall(3);
    bus.tx_data = 8'h00;
    n = 0;
    while (!(bus.done || bus.error) && n < 5000) begin @(negedge clk); n++; end
    bus.tx_valid = 1'b0;
    chk("hold_done", bus.done, 1);
    repeat (30) @(negedge clk);
    chk("hold_no_requeue", bus.ps2_clk_oe, 0);
    chk("hold_ready", bus.tx_ready, 1);
    chk("hold_q_empty", 32'(exp_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
